// File: rtl/cpu_ram_sync.sv
// Single-port synchronous RAM for the CPU data path with selectable read latency,
// read-during-write mode, and a hardware clear engine that owns the array while busy.
module cpu_ram_sync #(
    parameter int unsigned       DATA_W   = 4,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       READ_LAT = 1,
    parameter int unsigned       RDW_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              clr,
    output logic [DATA_W-1:0] douta,
    output logic              rvalid,
    output logic              busy
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : gen_bad_lat
        $error("cpu_ram_sync: READ_LAT must be 1 or 2");
    end

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
    logic              acc;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] mem [DEPTH];

    assign busy = (state_q == StClear);
    assign acc  = enable & ~busy;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StClear: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Array has no reset; contents survive reset and are only rewritten by the clear engine.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem[clr_addr_q[ADDR_W-1:0]] <= CLR_VAL;
            end else if (enable && wea) begin
                mem[addra] <= dina;
            end
        end
    end

    assign rdata = ((RDW_MODE != 0) && wea) ? dina : mem[addra];

    if (READ_LAT == 1) begin : gen_lat1
        always_ff @(posedge clk) begin
            if (reset) begin
                douta  <= '0;
                rvalid <= 1'b0;
            end else begin
                rvalid <= acc;
                if (acc) begin
                    douta <= rdata;
                end
            end
        end
    end else begin : gen_lat2
        logic [DATA_W-1:0] data1_q;
        logic              valid1_q;

        // Second stage is not gated by busy so reads in flight at a clr still complete.
        always_ff @(posedge clk) begin
            if (reset) begin
                data1_q  <= '0;
                valid1_q <= 1'b0;
                douta    <= '0;
                rvalid   <= 1'b0;
            end else begin
                valid1_q <= acc;
                if (acc) begin
                    data1_q <= rdata;
                end
                rvalid <= valid1_q;
                if (valid1_q) begin
                    douta <= data1_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_ram_sync.sv
// Scoreboard bench: three cpu_ram_sync instances (lat1/read-first, lat2/write-first,
// and a wide 64-deep lat2 variant); expected read data and arrival cycle are queued.
module tb_cpu_ram_sync;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, wea, clr;
    logic [3:0] addra, dina;
    logic [3:0] douta_a, douta_b;
    logic       rvalid_a, rvalid_b, busy_a, busy_b;

    logic       reset_c, enable_c, wea_c, clr_c;
    logic [5:0] addra_c;
    logic [7:0] dina_c, douta_c;
    logic       rvalid_c, busy_c;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    cpu_ram_sync #(.DATA_W(4), .ADDR_W(4), .READ_LAT(1), .RDW_MODE(0), .CLR_VAL(4'h0)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .wea(wea), .addra(addra), .dina(dina),
        .clr(clr), .douta(douta_a), .rvalid(rvalid_a), .busy(busy_a)
    );

    cpu_ram_sync #(.DATA_W(4), .ADDR_W(4), .READ_LAT(2), .RDW_MODE(1), .CLR_VAL(4'h0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .wea(wea), .addra(addra), .dina(dina),
        .clr(clr), .douta(douta_b), .rvalid(rvalid_b), .busy(busy_b)
    );

    cpu_ram_sync #(.DATA_W(8), .ADDR_W(6), .READ_LAT(2), .RDW_MODE(0), .CLR_VAL(8'h5A)) u_c (
        .clk(clk), .reset(reset_c), .enable(enable_c), .wea(wea_c), .addra(addra_c),
        .dina(dina_c), .clr(clr_c), .douta(douta_c), .rvalid(rvalid_c), .busy(busy_c)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every rvalid pulse must match the head of its queue in data and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a) begin
            if (qa.size() == 0) chk("a_spurious_rvalid", 32'(rvalid_a), 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_data", 32'(douta_a), 32'(e.data));
                chk("a_latency", cyc, e.cyc);
            end
        end
        if (rvalid_b) begin
            if (qb.size() == 0) chk("b_spurious_rvalid", 32'(rvalid_b), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_data", 32'(douta_b), 32'(e.data));
                chk("b_latency", cyc, e.cyc);
            end
        end
        if (rvalid_c) begin
            if (qc.size() == 0) chk("c_spurious_rvalid", 32'(rvalid_c), 32'd0);
            else begin
                e = qc.pop_front();
                chk("c_data", 32'(douta_c), 32'(e.data));
                chk("c_latency", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ea: expected read data from u_a (read-first); eb: from u_b (write-first).
    task automatic acc(input logic w, input logic [3:0] a, input logic [3:0] d,
                       input logic [3:0] ea, input logic [3:0] eb);
        enable = 1'b1;
        wea    = w;
        addra  = a;
        dina   = d;
        qa.push_back('{data: 8'(ea), cyc: cyc + 1});
        qb.push_back('{data: 8'(eb), cyc: cyc + 2});
        step();
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        wea    = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic acc_c(input logic w, input logic [5:0] a, input logic [7:0] d,
                         input logic [7:0] ec);
        enable_c = 1'b1;
        wea_c    = w;
        addra_c  = a;
        dina_c   = d;
        qc.push_back('{data: ec, cyc: cyc + 2});
        step();
    endtask

    task automatic busy_chk(input logic exp);
        chk("busy_a", 32'(busy_a), 32'(exp));
        chk("busy_b", 32'(busy_b), 32'(exp));
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 16; i++) acc(1'b0, 4'(i), 4'h0, 4'h0, 4'h0);
        idle(3);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; wea = 1'b0; clr = 1'b0; addra = '0; dina = '0;
        reset_c = 1'b1; enable_c = 1'b0; wea_c = 1'b0; clr_c = 1'b0;
        addra_c = '0; dina_c = '0;

        // Test 1: reset state, busy for exactly 16 cycles, array reads CLR_VAL.
        step();
        chk("rst_douta_a", 32'(douta_a), 32'd0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        busy_chk(1'b1);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            busy_chk(1'b1);
            step();
        end
        busy_chk(1'b0);
        read_all_zero();

        // Test 2: write then read back-to-back; douta holds afterwards.
        acc(1'b1, 4'd3, 4'hA, 4'h0, 4'hA);
        acc(1'b0, 4'd3, 4'h0, 4'hA, 4'hA);
        idle(3);
        chk("hold_douta_a", 32'(douta_a), 32'hA);

        // Test 3: read-during-write, read-first on u_a and write-first on u_b.
        acc(1'b1, 4'd5, 4'h2, 4'h0, 4'h2);
        acc(1'b1, 4'd5, 4'h7, 4'h2, 4'h7);
        idle(3);

        // Test 4: fill with 0xF, clear, and hammer writes while busy.
        for (int i = 0; i < 16; i++)
            acc(1'b1, 4'(i), 4'hF, (i == 3) ? 4'hA : ((i == 5) ? 4'h7 : 4'h0), 4'hF);
        idle(3);
        clr = 1'b1;
        step();
        clr    = 1'b0;
        enable = 1'b1;
        wea    = 1'b1;
        dina   = 4'h1;
        for (int i = 0; i < 16; i++) begin
            addra = 4'(i);
            clr   = (i == 4);
            busy_chk(1'b1);
            step();
        end
        enable = 1'b0;
        wea    = 1'b0;
        clr    = 1'b0;
        busy_chk(1'b0);
        chk("busy_hold_douta_b", 32'(douta_b), 32'hF);
        read_all_zero();

        // Test 5: access in the clr cycle, then reset at clear cycle 7 restarts the clear.
        clr = 1'b1;
        acc(1'b1, 4'd9, 4'h6, 4'h0, 4'h6);
        clr = 1'b0;
        idle(0);
        for (int i = 0; i < 6; i++) begin
            busy_chk(1'b1);
            step();
        end
        reset = 1'b1;
        step();
        chk("midclr_rst_douta_b", 32'(douta_b), 32'd0);
        chk("midclr_rst_rvalid_a", 32'(rvalid_a), 32'd0);
        busy_chk(1'b1);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            busy_chk(1'b1);
            step();
        end
        busy_chk(1'b0);
        read_all_zero();

        // Test 6: wide/deep variant with CLR_VAL 0x5A and READ_LAT 2.
        step();
        chk("c_rst_douta", 32'(douta_c), 32'd0);
        chk("c_rst_busy", 32'(busy_c), 32'd1);
        reset_c = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("c_busy", 32'(busy_c), 32'd1);
            step();
        end
        chk("c_busy_done", 32'(busy_c), 32'd0);
        acc_c(1'b1, 6'd63, 8'hC3, 8'h5A);
        acc_c(1'b0, 6'd63, 8'h00, 8'hC3);
        acc_c(1'b0, 6'd0,  8'h00, 8'h5A);
        enable_c = 1'b0;
        wea_c    = 1'b0;
        idle(4);

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        chk("c_queue_drained", 32'(qc.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
